// File: rtl/cpu_core_pkg.sv
// Shared types and encodings for cpu_core: FSM states, instruction classes, ALU ops,
// jump conditions and the HALT encoding.
package cpu_core_pkg;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StOpnd,
      StMem,
      StHalt
   } state_e;

   localparam logic [1:0] ClsAlu   = 2'b00;
   localparam logic [1:0] ClsLoad  = 2'b01;
   localparam logic [1:0] ClsStore = 2'b10;
   localparam logic [1:0] ClsJump  = 2'b11;

   typedef enum logic [2:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluXor,
      AluMov,
      AluShl,
      AluShr
   } alu_op_e;

   localparam logic [2:0] JmpAlways = 3'b000;
   localparam logic [2:0] JmpZ      = 3'b001;
   localparam logic [2:0] JmpNz     = 3'b010;
   localparam logic [2:0] JmpC      = 3'b011;

   localparam logic [7:0] InstrHalt = 8'h00;

   // Reserved conditions (f[2] set) never report taken.
   function automatic logic jump_taken(input logic [2:0] cond, input logic z, input logic c);
      logic taken;
      case (cond)
         JmpAlways: taken = 1'b1;
         JmpZ:      taken = z;
         JmpNz:     taken = ~z;
         JmpC:      taken = c;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core: result = a op b with zero and carry/borrow/shift-out flags.
module cpu_core_alu
   import cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              c
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      c      = 1'b0;
      unique case (op)
         AluAdd: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            c      = wide[DATA_W];
         end
         AluSub: begin
            // The extended MSB is set exactly when b > a, i.e. a borrow.
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            c      = wide[DATA_W];
         end
         AluAnd: result = a & b;
         AluOr:  result = a | b;
         AluXor: result = a ^ b;
         AluMov: result = b;
         AluShl: begin
            result = {b[DATA_W-2:0], 1'b0};
            c      = b[DATA_W-1];
         end
         AluShr: begin
            result = {1'b0, b[DATA_W-1:1]};
            c      = b[0];
         end
         default: ;
      endcase
      z = (result == '0);
   end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle CPU core: 8-bit instructions, eight registers (r0 = accumulator), req/ack memory
// port. Define CPU_CORE_TRAP_EN to halt with trap=1 on a reserved jump condition.
module cpu_core
   import cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              flag_z,
   output logic              flag_c,
   output logic              halted,
   output logic              trap
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
   logic [7:0]        ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];
   logic              z_q, z_d, c_q, c_d, trap_q, trap_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [1:0]        cls;
   logic [2:0]        fld_f, fld_s;
   logic              ack, reserved_trap;
   logic [ADDR_W-1:0] opnd_addr;
   logic [DATA_W-1:0] alu_res;
   logic              alu_z, alu_c;

   assign cls       = ir_q[7:6];
   assign fld_f     = ir_q[5:3];
   assign fld_s     = ir_q[2:0];
   assign ack       = req_q & mem_ack;
   assign pc_inc    = pc_q + ADDR_W'(1);
   assign opnd_addr = ADDR_W'(mem_rdata);

`ifdef CPU_CORE_TRAP_EN
   assign reserved_trap = fld_f[2];
`else
   assign reserved_trap = 1'b0;
`endif

   cpu_core_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .op    (alu_op_e'(fld_f)),
      .a     (regs_q[0]),
      .b     (regs_q[fld_s]),
      .result(alu_res),
      .z     (alu_z),
      .c     (alu_c)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      regs_d  = regs_q;
      z_d     = z_q;
      c_d     = c_q;
      trap_d  = trap_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         StFetch: begin
            // Only the first fetch after reset arrives here without a request in flight.
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = pc_q;
            end else if (mem_ack) begin
               ir_d    = mem_rdata[7:0];
               pc_d    = pc_inc;
               req_d   = 1'b0;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (ir_q == InstrHalt) begin
               state_d = StHalt;
            end else if (cls == ClsAlu) begin
               state_d = StExec;
            end else begin
               state_d = StOpnd;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end
         StExec: begin
            regs_d[0] = alu_res;
            z_d       = alu_z;
            c_d       = alu_c;
            state_d   = StFetch;
            req_d     = 1'b1;
            we_d      = 1'b0;
            addr_d    = pc_q;
         end
         StOpnd: begin
            if (ack) begin
               pc_d  = pc_inc;
               req_d = 1'b0;
               we_d  = 1'b0;
               if (cls == ClsJump) begin
                  if (reserved_trap) begin
                     trap_d  = 1'b1;
                     state_d = StHalt;
                  end else begin
                     if (jump_taken(fld_f, z_q, c_q)) begin
                        pc_d = opnd_addr;
                     end
                     state_d = StFetch;
                     req_d   = 1'b1;
                     addr_d  = pc_d;
                  end
               end else begin
                  state_d = StMem;
                  req_d   = 1'b1;
                  we_d    = (cls == ClsStore);
                  addr_d  = opnd_addr;
                  if (cls == ClsStore) begin
                     wdata_d = regs_q[fld_f];
                  end
               end
            end
         end
         StMem: begin
            if (ack) begin
               if (cls == ClsLoad) begin
                  regs_d[fld_f] = mem_rdata;
               end
               state_d = StFetch;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end
         StHalt: ;
         default: begin
            state_d = StFetch;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         trap_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
         trap_q  <= trap_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         regs_q  <= regs_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign pc        = pc_q;
   assign acc       = regs_q[0];
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign halted    = (state_q == StHalt);
   assign trap      = trap_q;

endmodule
